// File: rtl/audio_mixer_sd_pkg.sv
// Shared sizing helpers for the audio mixer: clog2, accumulator width, saturation bounds.
package audio_mixer_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < n) r = i + 1;
        return r;
    endfunction

    function automatic int acc_w(input int in_w, input int gain_w, input int num_ch);
        return in_w + gain_w + 1 + clog2(num_ch);
    endfunction

    function automatic longint sat_max(input int in_w);
        return (longint'(1) << (in_w - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int in_w);
        return -(longint'(1) << (in_w - 1));
    endfunction

    localparam int     DEF_IN_W = 16;
    localparam longint SAT_MAX  = sat_max(DEF_IN_W);
    localparam longint SAT_MIN  = sat_min(DEF_IN_W);

endpackage

// File: rtl/audio_mixer_sd_modulator.sv
// 1-bit sigma-delta modulator; first-order carry type, or second-order when AUDIO_MIXER_SD_2ND_ORDER_EN is defined.
// Updates every clock from the held sample; no handshake, dac_out is registered.
module sd_modulator #(
    parameter int IN_W = 16
) (
    input  logic            clk_vga,
    input  logic            reset_wire,
    input  logic [IN_W-1:0] sample,
    output logic            dac_out
);

`ifdef AUDIO_MIXER_SD_2ND_ORDER_EN
    localparam int IW = IN_W + 4;
    localparam int EW = IN_W + 6;
    localparam logic signed [EW-1:0] I_MAX = {{(EW-IW+1){1'b0}}, {(IW-1){1'b1}}};
    localparam logic signed [EW-1:0] I_MIN = ~I_MAX;
    localparam logic signed [EW-1:0] FB_P  = EW'(longint'(1) << (IN_W - 1));

    logic signed [IW-1:0] i1, i2, i1_nxt, i2_nxt;
    logic signed [EW-1:0] x, fb, i1_sum, i2_sum;

    // Integrators clamp rather than wrap so large inputs cannot flip the loop sign.
    always_comb begin
        x      = {{(EW-IN_W){sample[IN_W-1]}}, sample};
        fb     = dac_out ? FB_P : -FB_P;
        i1_sum = {{(EW-IW){i1[IW-1]}}, i1} + x - fb;
        i1_nxt = (i1_sum > I_MAX) ? I_MAX[IW-1:0] :
                 (i1_sum < I_MIN) ? I_MIN[IW-1:0] : i1_sum[IW-1:0];
        i2_sum = {{(EW-IW){i2[IW-1]}}, i2} + {{(EW-IW){i1_nxt[IW-1]}}, i1_nxt} - fb;
        i2_nxt = (i2_sum > I_MAX) ? I_MAX[IW-1:0] :
                 (i2_sum < I_MIN) ? I_MIN[IW-1:0] : i2_sum[IW-1:0];
    end

    always_ff @(posedge clk_vga or posedge reset_wire) begin
        if (reset_wire) begin
            i1      <= '0;
            i2      <= '0;
            dac_out <= 1'b0;
        end else begin
            i1      <= i1_nxt;
            i2      <= i2_nxt;
            dac_out <= ~i2_nxt[IW-1];
        end
    end
`else
    logic [IN_W-1:0] sd1;
    logic [IN_W:0]   sd_sum;

    // Offset-binary input: carry-out density equals u / 2^IN_W.
    always_comb begin
        sd_sum = {1'b0, sd1} + {1'b0, ~sample[IN_W-1], sample[IN_W-2:0]};
    end

    always_ff @(posedge clk_vga or posedge reset_wire) begin
        if (reset_wire) begin
            sd1     <= '0;
            dac_out <= 1'b0;
        end else begin
            sd1     <= sd_sum[IN_W-1:0];
            dac_out <= sd_sum[IN_W];
        end
    end
`endif

endmodule

// File: rtl/audio_mixer_sd.sv
// N-channel gain/saturating mixer, one channel per clk_vga; mix_out every NUM_CH clocks, no backpressure.
// Feeds sd_modulator (order set by AUDIO_MIXER_SD_2ND_ORDER_EN) for the 1-bit dac_out.
module audio_mixer_sd #(
    parameter int NUM_CH     = 4,
    parameter int IN_W       = 16,
    parameter int GAIN_W     = 4,
    parameter int GAIN_SHIFT = 2
) (
    input  logic                     clk_vga,
    input  logic                     reset_wire,
    input  logic [NUM_CH*IN_W-1:0]   ch_data,
    input  logic [NUM_CH*GAIN_W-1:0] ch_gain,
    input  logic                     mute,
    output logic [IN_W-1:0]          mix_out,
    output logic                     mix_valid,
    output logic                     clip,
    output logic                     dac_out
);
    import audio_mixer_pkg::*;

    localparam int ACC_W = acc_w(IN_W, GAIN_W, NUM_CH);
    localparam int CH_W  = (NUM_CH > 1) ? clog2(NUM_CH) : 1;
    localparam logic [CH_W-1:0]         LAST_CH = CH_W'(NUM_CH - 1);
    localparam logic signed [ACC_W-1:0] SAT_HI  = ACC_W'(sat_max(IN_W));
    localparam logic signed [ACC_W-1:0] SAT_LO  = ACC_W'(sat_min(IN_W));

    logic [CH_W-1:0]         ch_idx;
    logic [IN_W-1:0]         smp;
    logic [GAIN_W-1:0]       gn;
    logic signed [ACC_W-1:0] acc, prod, base, sum, scaled;
    logic                    sat_hi, sat_lo, last_slot;
    logic [IN_W-1:0]         mix_next;

    // Slot 0 restarts from zero so a frame never inherits a previous partial sum.
    always_comb begin
        smp       = ch_data[ch_idx*IN_W +: IN_W];
        gn        = ch_gain[ch_idx*GAIN_W +: GAIN_W];
        prod      = $signed({{(ACC_W-IN_W){smp[IN_W-1]}}, smp}) *
                    $signed({{(ACC_W-GAIN_W){1'b0}}, gn});
        base      = (ch_idx == '0) ? '0 : acc;
        sum       = base + prod;
        scaled    = sum >>> GAIN_SHIFT;
        sat_hi    = scaled > SAT_HI;
        sat_lo    = scaled < SAT_LO;
        mix_next  = sat_hi ? SAT_HI[IN_W-1:0] :
                    sat_lo ? SAT_LO[IN_W-1:0] : scaled[IN_W-1:0];
        last_slot = (ch_idx == LAST_CH);
    end

    always_ff @(posedge clk_vga or posedge reset_wire) begin
        if (reset_wire) begin
            ch_idx    <= '0;
            acc       <= '0;
            mix_out   <= '0;
            mix_valid <= 1'b0;
            clip      <= 1'b0;
        end else begin
            acc       <= sum;
            ch_idx    <= last_slot ? '0 : ch_idx + 1'b1;
            mix_valid <= last_slot;
            if (last_slot) begin
                mix_out <= mute ? '0 : mix_next;
                clip    <= ~mute & (sat_hi | sat_lo);
            end
        end
    end

    sd_modulator #(.IN_W(IN_W)) u_mod (
        .clk_vga    (clk_vga),
        .reset_wire (reset_wire),
        .sample     (mix_out),
        .dac_out    (dac_out)
    );

endmodule

// File: tb/tb_audio_mixer_sd.sv
// Directed bench for audio_mixer_sd with default parameters and first-order modulator.
module tb_audio_mixer_sd;
    localparam int NUM_CH = 4;
    localparam int IN_W   = 16;
    localparam int GAIN_W = 4;
    localparam int DAC_N  = 16384;

    logic                     clk_vga = 1'b0;
    logic                     reset_wire;
    logic [NUM_CH*IN_W-1:0]   ch_data;
    logic [NUM_CH*GAIN_W-1:0] ch_gain;
    logic                     mute;
    logic [IN_W-1:0]          mix_out;
    logic                     mix_valid;
    logic                     clip;
    logic                     dac_out;

    int total = 0;
    int bad   = 0;

    audio_mixer_sd #(.NUM_CH(NUM_CH), .IN_W(IN_W), .GAIN_W(GAIN_W), .GAIN_SHIFT(2)) dut (
        .clk_vga    (clk_vga),
        .reset_wire (reset_wire),
        .ch_data    (ch_data),
        .ch_gain    (ch_gain),
        .mute       (mute),
        .mix_out    (mix_out),
        .mix_valid  (mix_valid),
        .clip       (clip),
        .dac_out    (dac_out)
    );

    always #5 clk_vga = ~clk_vga;

    task automatic tick;
        @(posedge clk_vga);
        #1;
    endtask

    task automatic set_ch(input int k, input logic [IN_W-1:0] d, input logic [GAIN_W-1:0] g);
        ch_data[k*IN_W +: IN_W]     = d;
        ch_gain[k*GAIN_W +: GAIN_W] = g;
    endtask

    task automatic clear_ch;
        ch_data = '0;
        ch_gain = '0;
        mute    = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (mix_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Two pulses guarantee the reported frame was accumulated entirely from current inputs.
    task automatic settle(output bit ok);
        bit a, b;
        wait_valid(a);
        wait_valid(b);
        ok = a & b;
    endtask

    task automatic test_reset;
        int n;
        clear_ch();
        reset_wire = 1'b1;
        repeat (3) tick();
        total++; if (mix_out !== 16'h0000) begin bad++; $display("FAIL rst_mix got=%h exp=0000", mix_out); end
        total++; if (mix_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", mix_valid); end
        total++; if (clip !== 1'b0) begin bad++; $display("FAIL rst_clip got=%b exp=0", clip); end
        total++; if (dac_out !== 1'b0) begin bad++; $display("FAIL rst_dac got=%b exp=0", dac_out); end
        reset_wire = 1'b0;
        n = 0;
        do begin tick(); n++; end while (!mix_valid && n < 16);
        total++; if (n !== 4) begin bad++; $display("FAIL rst_first_valid got=%0d exp=4", n); end
    endtask

    task automatic test_unity;
        bit ok;
        int n, ones;
        clear_ch();
        set_ch(0, 16'h4000, 4'd4);
        set_ch(1, 16'h7FFF, 4'd0);
        set_ch(2, 16'h8000, 4'd0);
        set_ch(3, 16'h1234, 4'd0);
        settle(ok);
        total++; if (!ok) begin bad++; $display("FAIL unity_timeout got=%b exp=1", ok); end
        total++; if (mix_out !== 16'h4000) begin bad++; $display("FAIL unity_mix got=%h exp=4000", mix_out); end
        total++; if (clip !== 1'b0) begin bad++; $display("FAIL unity_clip got=%b exp=0", clip); end
        tick();
        total++; if (mix_valid !== 1'b0) begin bad++; $display("FAIL unity_pulse_width got=%b exp=0", mix_valid); end
        n = 1;
        do begin tick(); n++; end while (!mix_valid && n < 16);
        total++; if (n !== 4) begin bad++; $display("FAIL unity_period got=%0d exp=4", n); end
        ones = 0;
        repeat (DAC_N) begin tick(); ones += int'(dac_out); end
        total++; if (ones < 12287 || ones > 12289) begin bad++; $display("FAIL unity_dac_ones got=%0d exp=12288", ones); end
    endtask

    task automatic test_pos_sat;
        bit ok;
        clear_ch();
        set_ch(0, 16'h7000, 4'd4);
        set_ch(1, 16'h7000, 4'd4);
        settle(ok);
        total++; if (mix_out !== 16'h7FFF || !ok) begin bad++; $display("FAIL pos_sat_mix got=%h exp=7fff", mix_out); end
        total++; if (clip !== 1'b1) begin bad++; $display("FAIL pos_sat_clip got=%b exp=1", clip); end
        set_ch(0, 16'h3FFF, 4'd4);
        set_ch(1, 16'h3FFF, 4'd4);
        settle(ok);
        total++; if (mix_out !== 16'h7FFE || !ok) begin bad++; $display("FAIL pos_near_mix got=%h exp=7ffe", mix_out); end
        total++; if (clip !== 1'b0) begin bad++; $display("FAIL pos_near_clip got=%b exp=0", clip); end
        set_ch(0, 16'h7FFF, 4'd4);
        set_ch(1, 16'h0000, 4'd0);
        settle(ok);
        total++; if (mix_out !== 16'h7FFF || !ok) begin bad++; $display("FAIL pos_edge_mix got=%h exp=7fff", mix_out); end
        total++; if (clip !== 1'b0) begin bad++; $display("FAIL pos_edge_clip got=%b exp=0", clip); end
    endtask

    task automatic test_neg_sat_gain;
        bit ok;
        clear_ch();
        set_ch(0, 16'h8000, 4'd4);
        set_ch(1, 16'hC000, 4'd4);
        settle(ok);
        total++; if (mix_out !== 16'h8000 || !ok) begin bad++; $display("FAIL neg_sat_mix got=%h exp=8000", mix_out); end
        total++; if (clip !== 1'b1) begin bad++; $display("FAIL neg_sat_clip got=%b exp=1", clip); end
        set_ch(1, 16'h0000, 4'd0);
        settle(ok);
        total++; if (mix_out !== 16'h8000 || clip !== 1'b0 || !ok) begin bad++; $display("FAIL neg_edge got=%h/%b exp=8000/0", mix_out, clip); end
        clear_ch();
        set_ch(0, 16'h1000, 4'd15);
        settle(ok);
        total++; if (mix_out !== 16'h3C00 || !ok) begin bad++; $display("FAIL gain15_mix got=%h exp=3c00", mix_out); end
        set_ch(0, 16'hFFFF, 4'd1);
        settle(ok);
        total++; if (mix_out !== 16'hFFFF || !ok) begin bad++; $display("FAIL neg_shift_mix got=%h exp=ffff", mix_out); end
    endtask

    task automatic test_mix_all;
        bit ok;
        clear_ch();
        set_ch(0, 16'h1000, 4'd4);
        set_ch(1, 16'h0100, 4'd8);
        set_ch(2, 16'hF000, 4'd2);
        set_ch(3, 16'h0010, 4'd12);
        settle(ok);
        total++; if (mix_out !== 16'h0A30 || !ok) begin bad++; $display("FAIL mix_all got=%h exp=0a30", mix_out); end
        total++; if (clip !== 1'b0) begin bad++; $display("FAIL mix_all_clip got=%b exp=0", clip); end
    endtask

    task automatic test_mute;
        bit ok;
        int ones;
        clear_ch();
        set_ch(0, 16'h7000, 4'd4);
        set_ch(1, 16'h7000, 4'd4);
        mute = 1'b1;
        settle(ok);
        total++; if (mix_out !== 16'h0000 || clip !== 1'b0 || !ok) begin bad++; $display("FAIL mute_sat got=%h/%b exp=0000/0", mix_out, clip); end
        set_ch(1, 16'h0000, 4'd0);
        set_ch(0, 16'h2000, 4'd4);
        settle(ok);
        total++; if (!ok) begin bad++; $display("FAIL mute_valid got=%b exp=1", ok); end
        total++; if (mix_out !== 16'h0000) begin bad++; $display("FAIL mute_mix got=%h exp=0000", mix_out); end
        ones = 0;
        repeat (DAC_N) begin tick(); ones += int'(dac_out); end
        total++; if (ones < 8191 || ones > 8193) begin bad++; $display("FAIL mute_dac_ones got=%0d exp=8192", ones); end
        mute = 1'b0;
    endtask

    task automatic test_reset_mid_frame;
        bit ok;
        int n;
        clear_ch();
        set_ch(0, 16'h1000, 4'd15);
        set_ch(2, 16'h0400, 4'd4);
        settle(ok);
        total++; if (mix_out !== 16'h4000 || !ok) begin bad++; $display("FAIL mid_pre_mix got=%h exp=4000", mix_out); end
        tick();
        tick();
        reset_wire = 1'b1;
        #1;
        total++; if (mix_out !== 16'h0000 || mix_valid !== 1'b0) begin bad++; $display("FAIL mid_rst got=%h/%b exp=0000/0", mix_out, mix_valid); end
        total++; if (dac_out !== 1'b0 || clip !== 1'b0) begin bad++; $display("FAIL mid_rst_dac got=%b/%b exp=0/0", dac_out, clip); end
        tick();
        tick();
        reset_wire = 1'b0;
        n = 0;
        do begin tick(); n++; end while (!mix_valid && n < 16);
        total++; if (n !== 4) begin bad++; $display("FAIL mid_first_valid got=%0d exp=4", n); end
        total++; if (mix_out !== 16'h4000) begin bad++; $display("FAIL mid_first_mix got=%h exp=4000", mix_out); end
    endtask

    initial begin
        reset_wire = 1'b1;
        clear_ch();
        test_reset();
        test_unity();
        test_pos_sat();
        test_neg_sat_gain();
        test_mix_all();
        test_mute();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
